// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared state encoding and default constants for the scan BIST
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SHIFT,
        ST_CAPTURE,
        ST_FLUSH,
        ST_COMPARE,
        ST_DONE
    } bist_state_t;

    localparam int         BIST_SCAN_LEN = 6;
    localparam int         BIST_N_PAT    = 100;
    localparam int         BIST_SIG_W    = 8;
    localparam logic [7:0] BIST_GOLDEN   = 8'hA5;

endpackage

// File: rtl/bist_sequencer_if.sv
// rtl/bist_sequencer_if.sv - start/signature inputs and scan-control outputs of the BIST sequencer
interface bist_sequencer_if #(
    parameter int SIG_W = 8
);
    logic             bist_start;
    logic [SIG_W-1:0] sig;
    logic             scan_en;
    logic             tpg_rst;
    logic             misr_en;
    logic             running;
    logic             bist_end;
    logic             pass_fail;

    modport master (
        output bist_start, sig,
        input  scan_en, tpg_rst, misr_en, running, bist_end, pass_fail
    );

    modport slave (
        input  bist_start, sig,
        output scan_en, tpg_rst, misr_en, running, bist_end, pass_fail
    );
endinterface

// File: rtl/bist_start_edge.sv
// rtl/bist_start_edge.sv - rising-edge detect on bist_start; history resets high so a held level is not a start
module bist_start_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic edge_o
);
    logic start_q;
    logic start_d;

    assign start_d = level_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            start_q <= 1'b1;
        end else begin
            start_q <= start_d;
        end
    end

    assign edge_o = level_i & ~start_q;
endmodule

// File: rtl/bist_sequencer.sv
// rtl/bist_sequencer.sv - one FSM sequencing seed, shift/capture windows, flush and signature compare
module bist_sequencer
    import bist_pkg::*;
#(
    parameter int               SCAN_LEN = BIST_SCAN_LEN,
    parameter int               N_PAT    = BIST_N_PAT,
    parameter int               SIG_W    = BIST_SIG_W,
    parameter logic [SIG_W-1:0] GOLDEN   = SIG_W'(BIST_GOLDEN)
) (
    input logic              CLK,
    input logic              RST,
    bist_sequencer_if.slave  bus
);
    localparam int              SH_W    = $clog2(SCAN_LEN + 1);
    localparam int              PAT_W   = $clog2(N_PAT + 1);
    localparam logic [SH_W-1:0]  SH_LAST  = SH_W'(SCAN_LEN - 1);
    localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(N_PAT - 1);

    bist_state_t      state_q, state_d;
    logic [SH_W-1:0]  sh_cnt_q, sh_cnt_d;
    logic [PAT_W-1:0] pat_cnt_q, pat_cnt_d;
    logic             bist_end_q, bist_end_d;
    logic             pass_fail_q, pass_fail_d;
    logic             start_edge;

    bist_start_edge u_start_edge (
        .clk_i   (CLK),
        .rst_i   (RST),
        .level_i (bus.bist_start),
        .edge_o  (start_edge)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            sh_cnt_q    <= '0;
            pat_cnt_q   <= '0;
            bist_end_q  <= 1'b0;
            pass_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_cnt_q    <= sh_cnt_d;
            pat_cnt_q   <= pat_cnt_d;
            bist_end_q  <= bist_end_d;
            pass_fail_q <= pass_fail_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sh_cnt_d    = sh_cnt_q;
        pat_cnt_d   = pat_cnt_q;
        bist_end_d  = bist_end_q;
        pass_fail_d = pass_fail_q;
        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                sh_cnt_d    = '0;
                pat_cnt_d   = '0;
                bist_end_d  = 1'b0;
                pass_fail_d = 1'b0;
                state_d     = ST_SHIFT;
            end
            // FLUSH reuses the shift window to unload the final capture.
            ST_SHIFT, ST_FLUSH: begin
                if (sh_cnt_q == SH_LAST) begin
                    sh_cnt_d = '0;
                    state_d  = (state_q == ST_SHIFT) ? ST_CAPTURE : ST_COMPARE;
                end else begin
                    sh_cnt_d = sh_cnt_q + SH_W'(1);
                end
            end
            ST_CAPTURE: begin
                if (pat_cnt_q == PAT_LAST) begin
                    state_d = ST_FLUSH;
                end else begin
                    pat_cnt_d = pat_cnt_q + PAT_W'(1);
                    state_d   = ST_SHIFT;
                end
            end
            // Result lands on the edge into DONE so bist_end is visible during DONE.
            ST_COMPARE: begin
                pass_fail_d = (bus.sig == GOLDEN);
                bist_end_d  = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                state_d = start_edge ? ST_INIT : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.scan_en   = (state_q == ST_SHIFT) || (state_q == ST_FLUSH);
    assign bus.misr_en   = (state_q == ST_SHIFT) || (state_q == ST_CAPTURE) ||
                           (state_q == ST_FLUSH);
    assign bus.tpg_rst   = (state_q == ST_INIT);
    assign bus.running   = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign bus.bist_end  = bist_end_q;
    assign bus.pass_fail = pass_fail_q;
endmodule

// File: tb/tb_bist_sequencer.sv
// tb/tb_bist_sequencer.sv - reduced (3x2) and default (6x100) sequencers checked against a run-offset model
module tb_bist_sequencer;

    logic clk;
    logic rst;

    bist_sequencer_if #(.SIG_W(8)) ifa ();
    bist_sequencer_if #(.SIG_W(8)) ifb ();

    bist_sequencer #(
        .SCAN_LEN (3),
        .N_PAT    (2),
        .SIG_W    (8),
        .GOLDEN   (8'h3C)
    ) dut_a (
        .CLK (clk),
        .RST (rst),
        .bus (ifa)
    );

    bist_sequencer dut_b (
        .CLK (clk),
        .RST (rst),
        .bus (ifb)
    );

    int total = 0;
    int bad   = 0;

    bit       m_act  [2];
    bit       m_end  [2];
    bit       m_pf   [2];
    bit       m_prev [2];
    int       m_t    [2];
    bit [7:0] sig_tgt[2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int ps(input int d);
        return (d == 0) ? 3 : 6;
    endfunction

    function automatic int pn(input int d);
        return (d == 0) ? 2 : 100;
    endfunction

    function automatic bit [7:0] pg(input int d);
        return (d == 0) ? 8'h3C : 8'hA5;
    endfunction

    // Edge index (from the start-sampling edge) at which DONE is entered.
    function automatic int run_len(input int d);
        return 1 + pn(d) * (ps(d) + 1) + ps(d) + 1;
    endfunction

    function automatic logic get_start(input int d);
        return (d == 0) ? ifa.bist_start : ifb.bist_start;
    endfunction
    function automatic logic [7:0] get_sig(input int d);
        return (d == 0) ? ifa.sig : ifb.sig;
    endfunction
    function automatic logic get_scan(input int d);
        return (d == 0) ? ifa.scan_en : ifb.scan_en;
    endfunction
    function automatic logic get_tpg(input int d);
        return (d == 0) ? ifa.tpg_rst : ifb.tpg_rst;
    endfunction
    function automatic logic get_misr(input int d);
        return (d == 0) ? ifa.misr_en : ifb.misr_en;
    endfunction
    function automatic logic get_run(input int d);
        return (d == 0) ? ifa.running : ifb.running;
    endfunction
    function automatic logic get_end(input int d);
        return (d == 0) ? ifa.bist_end : ifb.bist_end;
    endfunction
    function automatic logic get_pf(input int d);
        return (d == 0) ? ifa.pass_fail : ifb.pass_fail;
    endfunction

    task automatic set_start(input int d, input logic v);
        if (d == 0) ifa.bist_start = v;
        else        ifb.bist_start = v;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad < 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a run is just an offset t from the start edge; outputs follow from t arithmetically.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int L;
            bit e;
            L = run_len(d);
            if (rst) begin
                m_act[d]  = 1'b0;
                m_t[d]    = 0;
                m_end[d]  = 1'b0;
                m_pf[d]   = 1'b0;
                m_prev[d] = 1'b1;
            end else begin
                e = get_start(d) && !m_prev[d];
                m_prev[d] = get_start(d);
                if (m_act[d]) begin
                    if (m_t[d] == 0) begin
                        m_end[d] = 1'b0;
                        m_pf[d]  = 1'b0;
                    end
                    if (m_t[d] == L - 1) begin
                        m_end[d] = 1'b1;
                        m_pf[d]  = (get_sig(d) == pg(d));
                    end
                    if (m_t[d] == L) begin
                        if (e) m_t[d] = 0;
                        else   m_act[d] = 1'b0;
                    end else begin
                        m_t[d]++;
                    end
                end else if (e) begin
                    m_act[d] = 1'b1;
                    m_t[d]   = 0;
                end
            end
        end
    end

    // sig carries the target only while the model says COMPARE; noise otherwise.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [7:0] v;
            v = (m_act[d] && m_t[d] == run_len(d) - 1) ? sig_tgt[d] : 8'($urandom);
            if (d == 0) ifa.sig = v;
            else        ifb.sig = v;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            bit sc, tp, me, ru;
            int t, S, body;
            sc = 0; tp = 0; me = 0; ru = 0;
            S = ps(d);
            body = pn(d) * (S + 1);
            t = m_t[d];
            if (m_act[d]) begin
                if (t == 0) begin
                    tp = 1; ru = 1;
                end else if (t <= body) begin
                    ru = 1; me = 1; sc = (((t - 1) % (S + 1)) != S);
                end else if (t <= body + S) begin
                    ru = 1; me = 1; sc = 1;
                end else if (t == body + S + 1) begin
                    ru = 1;
                end
            end
            check($sformatf("scan_en[%0d]", d),   32'(get_scan(d)), 32'(sc));
            check($sformatf("tpg_rst[%0d]", d),   32'(get_tpg(d)),  32'(tp));
            check($sformatf("misr_en[%0d]", d),   32'(get_misr(d)), 32'(me));
            check($sformatf("running[%0d]", d),   32'(get_run(d)),  32'(ru));
            check($sformatf("bist_end[%0d]", d),  32'(get_end(d)),  32'(m_end[d]));
            check($sformatf("pass_fail[%0d]", d), 32'(get_pf(d)),   32'(m_pf[d]));
        end
    end

    task automatic start_run(input int d);
        set_start(d, 1'b0);
        @(negedge clk);
        set_start(d, 1'b1);
    endtask

    // n = edges since the start-sampling edge, observed at the following negedge.
    task automatic wait_done(input int d, input int exp_edges, input logic exp_pf,
                             input int reedge_at, input bit drop_at_end, input bit chk_pat);
        bit seen;
        int tp;
        bit exp_pat [11];
        exp_pat = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1};
        seen = 0;
        tp = 0;
        for (int n = 0; n < exp_edges + 20 && !seen; n++) begin
            @(negedge clk);
            if (get_tpg(d)) tp++;
            if (n == 0) check("lit_init_tpg", 32'(get_tpg(d)), 32'd1);
            if (n == 1) begin
                check("lit_init_clr_end", 32'(get_end(d)), 32'd0);
                check("lit_init_clr_pf",  32'(get_pf(d)),  32'd0);
            end
            if (chk_pat && n >= 1 && n <= 11)
                check($sformatf("lit_scan_pat%0d", n), 32'(get_scan(d)), 32'(exp_pat[n-1]));
            if (n == reedge_at)     set_start(d, 1'b0);
            if (n == reedge_at + 2) set_start(d, 1'b1);
            if (drop_at_end && n == exp_edges - 1) set_start(d, 1'b0);
            if (n >= 1 && get_end(d) === 1'b1) begin
                seen = 1;
                check("lit_done_edges", 32'(n), 32'(exp_edges));
                check("lit_pass_fail",  32'(get_pf(d)), 32'(exp_pf));
            end
        end
        if (!seen) check("lit_done_timeout", 32'd0, 32'd1);
        check("lit_tpg_once", 32'(tp), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        ifa.bist_start = 1'b1;
        ifb.bist_start = 1'b1;
        ifa.sig = 8'h00;
        ifb.sig = 8'h00;
        sig_tgt[0] = 8'h3C;
        sig_tgt[1] = 8'hA5;
        repeat (3) @(negedge clk);
        check("lit_rst_running", 32'(ifb.running),  32'd0);
        check("lit_rst_end",     32'(ifb.bist_end), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("lit_held_start_a", 32'(ifa.running), 32'd0);
            check("lit_held_start_b", 32'(ifb.running), 32'd0);
        end

        start_run(0);
        wait_done(0, 13, 1'b1, -10, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        sig_tgt[0] = 8'h3C ^ 8'h01;
        start_run(0);
        wait_done(0, 13, 1'b0, -10, 1'b0, 1'b1);
        repeat (2) @(negedge clk);

        // Reset during the 5th SHIFT cycle of a default run.
        start_run(1);
        for (int n = 0; n <= 5; n++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("lit_mid_rst_scan", 32'(ifb.scan_en),   32'd0);
        check("lit_mid_rst_misr", 32'(ifb.misr_en),   32'd0);
        check("lit_mid_rst_run",  32'(ifb.running),   32'd0);
        check("lit_mid_rst_end",  32'(ifb.bist_end),  32'd0);
        check("lit_mid_rst_pf",   32'(ifb.pass_fail), 32'd0);
        check("lit_mid_rst_a_end", 32'(ifa.bist_end), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        start_run(1);
        wait_done(1, 708, 1'b1, 100, 1'b1, 1'b0);
        set_start(1, 1'b1);
        sig_tgt[1] = 8'hA5 ^ 8'h01;
        wait_done(1, 708, 1'b0, -10, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("lit_idle_after_run", 32'(ifb.running), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
